regfile_wr_arbiter: RTL and testbench

//  Shares the two write ports of the 16-entry regfile between NREQ independent write requesters.

---
 rtl/regfile_wr_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter granting up to two writes per cycle onto the regfile's
// two write ports, never two to the same register in one cycle.
module regfile_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
    input  logic [NREQ*DATAWIDTH-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      write,
    output logic [ADDRWIDTH-1:0]      writeReg1,
    output logic [ADDRWIDTH-1:0]      writeReg2,
    output logic [DATAWIDTH-1:0]      writeData1,
    output logic [DATAWIDTH-1:0]      writeData2
);

    localparam int PTRW = $clog2(NREQ);

    logic [ADDRWIDTH-1:0] addr_v [NREQ];
    logic [DATAWIDTH-1:0] data_v [NREQ];
    logic [PTRW-1:0]      rr_ptr;
    logic [PTRW-1:0]      next_ptr;
    logic [PTRW-1:0]      a_idx;
    logic [PTRW-1:0]      b_idx;
    logic                 a_found;
    logic                 b_found;
    logic [NREQ-1:0]      grant;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_v[g] = req_addr[g*ADDRWIDTH +: ADDRWIDTH];
        assign data_v[g] = req_data[g*DATAWIDTH +: DATAWIDTH];
    end

    function automatic logic [PTRW-1:0] wrap_add(input logic [PTRW-1:0] p,
                                                 input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return PTRW'(s);
    endfunction

    // Slot B skips anything colliding with slot A's address.
    always_comb begin
        logic [PTRW-1:0] idx;
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = wrap_add(rr_ptr, k);
            if (req_valid[idx]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = idx;
                end else if (!b_found && addr_v[idx] != addr_v[a_idx]) begin
                    b_found = 1'b1;
                    b_idx   = idx;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (a_found) grant[a_idx] = 1'b1;
        if (b_found) grant[b_idx] = 1'b1;
        next_ptr = wrap_add(b_found ? b_idx : a_idx, 1);
    end

    assign req_ready = resetn ? grant : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            write      <= 1'b0;
            writeReg1  <= '0;
            writeReg2  <= '0;
            writeData1 <= '0;
            writeData2 <= '0;
            rr_ptr     <= '0;
        end else begin
            write <= a_found;
            if (a_found) begin
                writeReg1  <= addr_v[a_idx];
                writeData1 <= data_v[a_idx];
                writeReg2  <= b_found ? addr_v[b_idx] : addr_v[a_idx];
                writeData2 <= b_found ? data_v[b_idx] : data_v[a_idx];
                rr_ptr     <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural model and a regfile image.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 4;

    logic               clk = 1'b0;
    logic               resetn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               write;
    logic [AW-1:0]      writeReg1, writeReg2;
    logic [DW-1:0]      writeData1, writeData2;

    regfile_wr_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .write(write),
        .writeReg1(writeReg1), .writeReg2(writeReg2),
        .writeData1(writeData1), .writeData2(writeData2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: pointer, expected registered outputs, regfile image.
    int            m_ptr;
    logic          m_write;
    logic [AW-1:0] m_r1, m_r2;
    logic [DW-1:0] m_d1, m_d2;
    logic [DW-1:0] tb_rf    [16];
    logic [DW-1:0] last_val [16];
    bit            written  [16];

    function automatic logic [NREQ-1:0] mdl_grant(
        input int ptr, input logic [NREQ-1:0] v,
        input logic [NREQ*AW-1:0] a, output int first, output int second);
        logic [NREQ-1:0] g;
        g = '0;
        first = -1;
        second = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (v[i]) begin
                if (first < 0) begin
                    first = i;
                    g[i] = 1'b1;
                end else if (second < 0 && a[i*AW +: AW] != a[first*AW +: AW]) begin
                    second = i;
                    g[i] = 1'b1;
                end
            end
        end
        return g;
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            m_ptr = 0;
            m_write = 1'b0;
            m_r1 = '0; m_r2 = '0; m_d1 = '0; m_d2 = '0;
            for (int a = 0; a < 16; a++) written[a] = 1'b0;
        end else begin
            logic [NREQ-1:0] g;
            int f, s;
            if (write) begin
                tb_rf[writeReg1] = writeData1;
                tb_rf[writeReg2] = writeData2;
            end
            chk("mdl_write", {63'd0, write}, {63'd0, m_write});
            chk("mdl_reg1", {60'd0, writeReg1}, {60'd0, m_r1});
            chk("mdl_reg2", {60'd0, writeReg2}, {60'd0, m_r2});
            chk("mdl_data1", {32'd0, writeData1}, {32'd0, m_d1});
            chk("mdl_data2", {32'd0, writeData2}, {32'd0, m_d2});
            g = mdl_grant(m_ptr, req_valid, req_addr, f, s);
            chk("mdl_ready", {60'd0, req_ready}, {60'd0, g});
            m_write = (f >= 0);
            if (f >= 0) begin
                m_r1 = req_addr[f*AW +: AW];
                m_d1 = req_data[f*DW +: DW];
                last_val[m_r1] = m_d1;
                written[m_r1] = 1'b1;
                if (s >= 0) begin
                    m_r2 = req_addr[s*AW +: AW];
                    m_d2 = req_data[s*DW +: DW];
                    last_val[m_r2] = m_d2;
                    written[m_r2] = 1'b1;
                    m_ptr = (s + 1) % NREQ;
                end else begin
                    m_r2 = m_r1;
                    m_d2 = m_d1;
                    m_ptr = (f + 1) % NREQ;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i] = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
    endtask

    logic [NREQ-1:0] acc;
    logic [DW-1:0]   pat [4];

    initial begin
        pat[0] = 32'hAAAAAAAA; pat[1] = 32'hBBBBBBBB;
        pat[2] = 32'hCCCCCCCC; pat[3] = 32'hDDDDDDDD;
        for (int a = 0; a < 16; a++) begin
            tb_rf[a] = '0;
            last_val[a] = '0;
        end
        resetn = 1'b0;
        clear_reqs();
        set_req(1, 1'b1, 4'd2, 32'h1234);
        #12;
        chk("rst_ready", {60'd0, req_ready}, 64'd0);
        chk("rst_write", {63'd0, write}, 64'd0);
        chk("rst_reg1", {60'd0, writeReg1}, 64'd0);
        chk("rst_data2", {32'd0, writeData2}, 64'd0);
        tick();
        clear_reqs();
        tick();
        resetn = 1'b1;

        // single request
        tick();
        set_req(0, 1'b1, 4'd3, 32'hAAAAAAAA);
        @(negedge clk);
        chk("single_ready", {60'd0, req_ready}, 64'h1);
        tick();
        set_req(0, 1'b0, '0, '0);
        @(negedge clk);
        chk("single_write", {63'd0, write}, 64'd1);
        chk("single_reg1", {60'd0, writeReg1}, 64'd3);
        chk("single_reg2", {60'd0, writeReg2}, 64'd3);
        chk("single_data1", {32'd0, writeData1}, 64'hAAAAAAAA);
        chk("single_data2", {32'd0, writeData2}, 64'hAAAAAAAA);
        tick();
        @(negedge clk);
        chk("single_idle", {63'd0, write}, 64'd0);

        // same-address conflict, pointer now at 1
        tick();
        set_req(1, 1'b1, 4'd5, 32'hFACECAFE);
        set_req(2, 1'b1, 4'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("conf_c1", {60'd0, req_ready}, 64'h2);
        tick();
        set_req(1, 1'b0, '0, '0);
        @(negedge clk);
        chk("conf_c2", {60'd0, req_ready}, 64'h4);
        chk("conf_d1", {32'd0, writeData1}, 64'hFACECAFE);
        tick();
        set_req(2, 1'b0, '0, '0);
        tick();
        tick();
        chk("conf_r5", {32'd0, tb_rf[5]}, 64'hDEADBEEF);

        // fairness under full address contention
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 4'd7, DW'(i + 32'h700));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("fair_ready", {60'd0, req_ready}, 64'd1 << (c % 3));
            tick();
        end
        clear_reqs();
        tick();

        // reset while a write is pending on the port
        set_req(0, 1'b1, 4'd9, 32'h99);
        @(negedge clk);
        chk("rst2_grant", {60'd0, req_ready}, 64'h1);
        tick();
        chk("rst2_pending", {63'd0, write}, 64'd1);
        resetn = 1'b0;
        #1;
        chk("rst2_write", {63'd0, write}, 64'd0);
        chk("rst2_ready", {60'd0, req_ready}, 64'd0);
        chk("rst2_reg1", {60'd0, writeReg1}, 64'd0);
        chk("rst2_data1", {32'd0, writeData1}, 64'd0);
        tick();

        // four distinct requests after release, pointer back at 0
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, AW'(i + 1), pat[i]);
        @(negedge clk);
        chk("rr_c1", {60'd0, req_ready}, 64'h3);
        tick();
        @(negedge clk);
        chk("rr_c2", {60'd0, req_ready}, 64'hC);
        chk("rr_c2_w", {63'd0, write}, 64'd1);
        chk("rr_c2_r1", {60'd0, writeReg1}, 64'd1);
        chk("rr_c2_r2", {60'd0, writeReg2}, 64'd2);
        tick();
        @(negedge clk);
        chk("rr_c3", {60'd0, req_ready}, 64'h3);
        chk("rr_c3_d1", {32'd0, writeData1}, 64'hCCCCCCCC);
        chk("rr_c3_d2", {32'd0, writeData2}, 64'hDDDDDDDD);
        tick();
        clear_reqs();
        @(negedge clk);
        chk("rr_c4_w", {63'd0, write}, 64'd1);
        chk("rr_c4_r2", {60'd0, writeReg2}, 64'd2);
        tick();

        // random traffic; valid/addr/data held until accepted
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 9) < 6)
                        set_req(i, 1'b1, AW'($urandom_range(0, 5)), $urandom);
                    else
                        set_req(i, 1'b0, '0, '0);
                end
            end
        end
        clear_reqs();
        repeat (4) tick();
        for (int a = 0; a < 16; a++)
            if (written[a]) chk("e2e_reg", {32'd0, tb_rf[a]}, {32'd0, last_val[a]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
